// File: rtl/cpu_seq_ctrl.sv
// Instruction-cycle sequencer: eight states per instruction, registered datapath controls.
// Optional single-step stall on instruction boundaries when SEQ_SINGLE_STEP_EN is defined.
module cpu_seq_ctrl #(
    parameter int unsigned NSTATE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       inc_pc,
    output logic       load_acc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       datactl_ena,
    output logic       halt
);

    if (NSTATE != 32'd8) begin : g_bad_nstate
        $error("cpu_seq_ctrl: NSTATE must be 8");
    end

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_e;

    state_e     state_q, state_d;
    logic       armed_q, armed_d;
    logic       halt_q, halt_d;
    // {datactl_ena, load_ir, wr, rd, load_pc, load_acc, inc_pc}
    logic [6:0] out_q, out_d;
    logic       run;
    logic       alu;
`ifdef SEQ_SINGLE_STEP_EN
    logic       stall_q, stall_d;
`endif

    assign alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        halt_d  = halt_q;
        out_d   = '0;
        run     = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        stall_d = stall_q;
`endif
        if (halt_q) begin
            state_d = S0;
        end else if (!armed_q) begin
            if (fetch) begin
                armed_d = 1'b1;
                state_d = S1;
                run     = 1'b1;
            end
        end else begin
`ifdef SEQ_SINGLE_STEP_EN
            // Stalled S0 shows no controls; a step releases straight into S1.
            if (stall_q) begin
                if (step) begin
                    stall_d = 1'b0;
                    state_d = S1;
                    run     = 1'b1;
                end
            end else if (state_q == S7 && !step) begin
                stall_d = 1'b1;
                state_d = S0;
            end else begin
                state_d = state_e'(state_q + 3'd1);
                run     = 1'b1;
            end
`else
            state_d = state_e'(state_q + 3'd1);
            run     = 1'b1;
`endif
        end

        if (run) begin
            unique case (state_d)
                S0: out_d = 7'b0101000;
                S1: out_d = 7'b0101001;
                S2: out_d = 7'b0000000;
                S3: begin
                    out_d = 7'b0000001;
                    if (opcode == OP_HLT) halt_d = 1'b1;
                end
                S4: begin
                    if (opcode == OP_JMP) out_d = 7'b0000100;
                    if (alu)              out_d = 7'b0001000;
                    if (opcode == OP_STO) out_d = 7'b1000000;
                end
                S5: begin
                    if (alu)                       out_d = 7'b0001010;
                    if (opcode == OP_SKZ && zero)  out_d = 7'b0000001;
                    if (opcode == OP_JMP)          out_d = 7'b0000101;
                    if (opcode == OP_STO)          out_d = 7'b1010000;
                end
                S6: begin
                    if (alu)              out_d = 7'b0001000;
                    if (opcode == OP_STO) out_d = 7'b1000000;
                end
                S7: begin
                    if (opcode == OP_SKZ && zero) out_d = 7'b0000001;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            armed_q <= 1'b0;
            halt_q  <= 1'b0;
            out_q   <= '0;
`ifdef SEQ_SINGLE_STEP_EN
            stall_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            halt_q  <= halt_d;
            out_q   <= out_d;
`ifdef SEQ_SINGLE_STEP_EN
            stall_q <= stall_d;
`endif
        end
    end

    assign {datactl_ena, load_ir, wr, rd, load_pc, load_acc, inc_pc} = out_q;
    assign halt = halt_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: driver queues hand-computed output vectors per clock,
// monitor pops and compares after each rising edge.
module tb_cpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fetch = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic       zero = 1'b0;
    logic       inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt;

    localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110, JMP = 3'b111;

    typedef struct {
        logic [7:0] exp;
        string      tag;
    } item_t;

    item_t sbq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    cpu_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .fetch      (fetch),
        .opcode     (opcode),
        .zero       (zero),
        .inc_pc     (inc_pc),
        .load_acc   (load_acc),
        .load_pc    (load_pc),
        .rd         (rd),
        .wr         (wr),
        .load_ir    (load_ir),
        .datactl_ena(datactl_ena),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    // Vector order: {halt, datactl_ena, load_ir, wr, rd, load_pc, load_acc, inc_pc}
    initial begin : monitor
        item_t      it;
        logic [7:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                it  = sbq.pop_front();
                act = {halt, datactl_ena, load_ir, wr, rd, load_pc, load_acc, inc_pc};
                n_cmp++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b", it.tag, act, it.exp);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic f, input logic [2:0] op, input logic z,
                       input logic [7:0] e, input string tag);
        item_t it;
        @(negedge clk);
        rst    = r;
        fetch  = f;
        opcode = op;
        zero   = z;
        it.exp = e;
        it.tag = tag;
        sbq.push_back(it);
    endtask

    // rows = {S1,S2,S3,S4,S5,S6,S7,S0} expected vectors after each of 8 edges
    task automatic instr(input logic f, input logic [2:0] op, input logic z,
                         input logic [63:0] rows, input string name);
        for (int k = 0; k < 8; k++)
            cyc(1'b0, f, op, z, rows[63-8*k -: 8], $sformatf("%s_s%0d", name, (k + 1) % 8));
    endtask

    initial begin : driver
        int wait_cnt;
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, HLT, 1'b0, 8'h00, "reset");
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, HLT, 1'b0, 8'h00, "unarmed");

        instr(1'b1, SKZ, 1'b0, 64'h29_00_01_00_00_00_00_28, "skz_z0");
        instr(1'b0, LDA, 1'b0, 64'h29_00_01_08_0A_08_00_28, "lda");
        instr(1'b0, STO, 1'b0, 64'h29_00_01_40_50_40_00_28, "sto");
        instr(1'b1, SKZ, 1'b1, 64'h29_00_01_00_01_00_01_28, "skz_z1");
        instr(1'b0, JMP, 1'b0, 64'h29_00_01_04_05_00_00_28, "jmp");

        cyc(1'b0, 1'b0, HLT, 1'b0, 8'h29, "hlt_s1");
        cyc(1'b0, 1'b0, HLT, 1'b0, 8'h00, "hlt_s2");
        cyc(1'b0, 1'b0, HLT, 1'b0, 8'h81, "hlt_s3");
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'(i % 2), (i % 3 == 0) ? JMP : STO, 1'b1, 8'h80, "halted");

        cyc(1'b1, 1'b0, ADD, 1'b0, 8'h00, "rst_halt");
        cyc(1'b0, 1'b0, ADD, 1'b0, 8'h00, "unarmed2");
        cyc(1'b0, 1'b1, ADD, 1'b0, 8'h29, "add_s1");
        cyc(1'b0, 1'b0, ADD, 1'b0, 8'h00, "add_s2");
        cyc(1'b0, 1'b0, ADD, 1'b0, 8'h01, "add_s3");
        cyc(1'b0, 1'b0, ADD, 1'b0, 8'h08, "add_s4");
        cyc(1'b0, 1'b0, ADD, 1'b0, 8'h0A, "add_s5");
        cyc(1'b1, 1'b0, ADD, 1'b0, 8'h00, "rst_mid");
        cyc(1'b0, 1'b0, ADD, 1'b0, 8'h00, "unarmed3");
        cyc(1'b0, 1'b0, ADD, 1'b0, 8'h00, "unarmed4");
        cyc(1'b1, 1'b1, ADD, 1'b0, 8'h00, "rst_fetch");
        cyc(1'b0, 1'b0, ADD, 1'b0, 8'h00, "after_rst_fetch");
        instr(1'b1, ADD, 1'b0, 64'h29_00_01_08_0A_08_00_28, "add_rearm");

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
